// File: rtl/level_sequencer.sv
// level_sequencer: START -> NUM_LEVELS play levels -> END, driven by edge-detected keys and collisions.
// Define LEVEL_SEQ_CHEAT_KEYS_EN to enable per-level skip keys (KEY_SKIP0+k) while in PLAY.
module level_sequencer #(
    parameter int unsigned NUM_LEVELS  = 8,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned HEX_W       = 4,
    parameter logic [7:0]  KEY_START   = 8'h2C,
    parameter logic [7:0]  KEY_RESTART = 8'h15,
    parameter logic [7:0]  KEY_SKIP0   = 8'h1E
) (
    input  logic                                                   CLK,
    input  logic                                                   reset,
    input  logic [7:0]                                             keycode0,
    input  logic [7:0]                                             keycode1,
    input  logic                                                   ts_collide,
    input  logic                                                   bs_collide,
    output logic [NUM_LEVELS+1:0]                                  background_number,
    output logic [((NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1)-1:0] level_idx,
    output logic [HEX_W-1:0]                                       HEXstate,
    output logic                                                   level_changed
);
    localparam int unsigned LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int unsigned BG_W  = NUM_LEVELS + 2;
    localparam int unsigned CD_W  = $clog2(HOLD_CYCLES) + 1;
    localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(NUM_LEVELS - 1);
    localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_END   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CD_W-1:0]   cooldown_q, cooldown_d;
    logic              level_changed_q, level_changed_d;
    logic              ts_prev_q, bs_prev_q, start_prev_q, restart_prev_q;
    logic              start_hit, restart_hit;
    logic              ts_evt, bs_evt, start_press, restart_press;
    logic              level_ok, change;
    logic              skip_valid;
    logic [LVL_W-1:0]  skip_target;

    assign start_hit     = (keycode0 == KEY_START) || (keycode1 == KEY_START);
    assign restart_hit   = (keycode0 == KEY_RESTART) || (keycode1 == KEY_RESTART);
    assign start_press   = start_hit && !start_prev_q;
    assign restart_press = restart_hit && !restart_prev_q;
    assign ts_evt        = ts_collide && !ts_prev_q;
    assign bs_evt        = bs_collide && !bs_prev_q;
    assign level_ok      = 32'(level_q) < NUM_LEVELS;

`ifdef LEVEL_SEQ_CHEAT_KEYS_EN
    logic [NUM_LEVELS-1:0] skip_prev_q, skip_hit;

    // Lowest-numbered newly pressed skip key that targets a different level wins.
    always_comb begin
        skip_valid  = 1'b0;
        skip_target = '0;
        for (int unsigned k = 0; k < NUM_LEVELS; k++) begin
            skip_hit[k] = (keycode0 == KEY_SKIP0 + 8'(k)) || (keycode1 == KEY_SKIP0 + 8'(k));
            if (!skip_valid && skip_hit[k] && !skip_prev_q[k] && (LVL_W'(k) != level_q)) begin
                skip_valid  = 1'b1;
                skip_target = LVL_W'(k);
            end
        end
    end
`else
    assign skip_valid  = 1'b0;
    assign skip_target = '0;
`endif

    always_comb begin
        state_d = state_q;
        level_d = '0;
        case (state_q)
            ST_START: begin
                if (start_press) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                level_d = level_q;
                if (!level_ok) begin
                    state_d = ST_START;
                    level_d = '0;
                end else if (skip_valid) begin
                    level_d = skip_target;
                end else if (cooldown_q == '0) begin
                    if (ts_evt && !bs_evt) begin
                        if (level_q == LAST_LVL) begin
                            state_d = ST_END;
                            level_d = '0;
                        end else begin
                            level_d = level_q + 1'b1;
                        end
                    end else if (bs_evt && !ts_evt && (level_q != '0)) begin
                        level_d = level_q - 1'b1;
                    end
                end
            end
            ST_END: begin
                if (restart_press) state_d = ST_START;
            end
            default: state_d = ST_START;
        endcase

        change          = (state_d != state_q) || (level_d != level_q);
        level_changed_d = change;
        if (state_d == ST_START)      cooldown_d = '0;
        else if (change)              cooldown_d = CD_LOAD;
        else if (cooldown_q != '0)    cooldown_d = cooldown_q - 1'b1;
        else                          cooldown_d = cooldown_q;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q         <= ST_START;
            level_q         <= '0;
            cooldown_q      <= '0;
            level_changed_q <= 1'b0;
            ts_prev_q       <= 1'b0;
            bs_prev_q       <= 1'b0;
            start_prev_q    <= 1'b0;
            restart_prev_q  <= 1'b0;
`ifdef LEVEL_SEQ_CHEAT_KEYS_EN
            skip_prev_q     <= '0;
`endif
        end else begin
            state_q         <= state_d;
            level_q         <= level_d;
            cooldown_q      <= cooldown_d;
            level_changed_q <= level_changed_d;
            ts_prev_q       <= ts_collide;
            bs_prev_q       <= bs_collide;
            start_prev_q    <= start_hit;
            restart_prev_q  <= restart_hit;
`ifdef LEVEL_SEQ_CHEAT_KEYS_EN
            skip_prev_q     <= skip_hit;
`endif
        end
    end

    // Illegal encodings decode as START so the select stays one-hot until recovery.
    always_comb begin
        background_number = BG_W'(1);
        HEXstate          = '0;
        level_idx         = '0;
        case (state_q)
            ST_PLAY: begin
                if (level_ok) begin
                    background_number = BG_W'(2) << level_q;
                    HEXstate          = HEX_W'(level_q) + HEX_W'(1);
                    level_idx         = level_q;
                end
            end
            ST_END: begin
                background_number = BG_W'(1) << (BG_W - 1);
                HEXstate          = HEX_W'(NUM_LEVELS + 1);
            end
            default: ;
        endcase
    end

    assign level_changed = level_changed_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench for level_sequencer: stimulus steps a behavioural game model and queues
// the expected outputs; an independent monitor compares them after each rising edge.
module tb_level_sequencer;
    localparam int unsigned NL    = 8;
    localparam int unsigned HOLD  = 4;
    localparam int unsigned HEX_W = 4;

    logic              CLK = 1'b0;
    logic              reset;
    logic [7:0]        keycode0, keycode1;
    logic              ts_collide, bs_collide;
    logic [NL+1:0]     background_number;
    logic [2:0]        level_idx;
    logic [HEX_W-1:0]  HEXstate;
    logic              level_changed;

    level_sequencer #(
        .NUM_LEVELS (NL),
        .HOLD_CYCLES(HOLD),
        .HEX_W      (HEX_W)
    ) dut (
        .CLK              (CLK),
        .reset            (reset),
        .keycode0         (keycode0),
        .keycode1         (keycode1),
        .ts_collide       (ts_collide),
        .bs_collide       (bs_collide),
        .background_number(background_number),
        .level_idx        (level_idx),
        .HEXstate         (HEXstate),
        .level_changed    (level_changed)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned bg;
        int unsigned hex;
        int unsigned lvl;
        int unsigned chg;
    } exp_t;

    exp_t sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Behavioural game model: 0 = START, 1 = PLAY, 2 = END.
    int m_state, m_level, m_cool;
    bit m_chg;
    bit p_ts, p_bs, p_start, p_restart;
    bit p_skip[NL];

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_state = 0; m_level = 0; m_cool = 0; m_chg = 0;
        p_ts = 0; p_bs = 0; p_start = 0; p_restart = 0;
        for (int k = 0; k < NL; k++) p_skip[k] = 0;
    endtask

    task automatic model_edge();
        bit s_hit, r_hit, ts_e, bs_e;
        bit sk_hit[NL];
        int ns, nl, tgt;
        s_hit = (keycode0 == 8'h2C) || (keycode1 == 8'h2C);
        r_hit = (keycode0 == 8'h15) || (keycode1 == 8'h15);
        ts_e  = ts_collide && !p_ts;
        bs_e  = bs_collide && !p_bs;
        for (int k = 0; k < NL; k++)
            sk_hit[k] = (int'(keycode0) == 8'h1E + k) || (int'(keycode1) == 8'h1E + k);
        ns = m_state; nl = m_level; tgt = -1;
        if (m_state == 0) begin
            if (s_hit && !p_start) begin ns = 1; nl = 0; end
        end else if (m_state == 1) begin
`ifdef LEVEL_SEQ_CHEAT_KEYS_EN
            for (int k = 0; k < NL; k++)
                if (tgt < 0 && sk_hit[k] && !p_skip[k] && k != m_level) tgt = k;
`endif
            if (tgt >= 0) nl = tgt;
            else if (m_cool == 0 && ts_e && !bs_e) begin
                if (m_level == NL - 1) begin ns = 2; nl = 0; end
                else nl = m_level + 1;
            end else if (m_cool == 0 && bs_e && !ts_e && m_level > 0) nl = m_level - 1;
        end else begin
            if (r_hit && !p_restart) ns = 0;
        end
        m_chg = (ns != m_state) || (nl != m_level);
        m_state = ns; m_level = nl;
        if (m_state == 0) m_cool = 0;
        else if (m_chg) m_cool = HOLD - 1;
        else if (m_cool > 0) m_cool--;
        p_ts = ts_collide; p_bs = bs_collide; p_start = s_hit; p_restart = r_hit;
        for (int k = 0; k < NL; k++) p_skip[k] = sk_hit[k];
    endtask

    task automatic push_expected();
        exp_t e;
        e.hex = (m_state == 0) ? 0 : (m_state == 1) ? m_level + 1 : NL + 1;
        e.bg  = 1 << e.hex;
        e.lvl = (m_state == 1) ? m_level : 0;
        e.chg = m_chg;
        sb_q.push_back(e);
    endtask

    // One clock of stimulus; rp fires a short asynchronous reset pulse before the edge.
    task automatic cycle(input logic [7:0] k0, input logic [7:0] k1, input logic ts, input logic bs,
                         input bit rp);
        @(negedge CLK);
        keycode0 = k0; keycode1 = k1; ts_collide = ts; bs_collide = bs;
        if (rp) begin
            reset = 1'b1;
            model_reset();
            #1;
            reset = 1'b0;
        end
        model_edge();
        push_expected();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ts_step();
        cycle(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(5);
    endtask

    task automatic bs_step();
        cycle(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(5);
    endtask

    function automatic logic [7:0] pick_key();
        logic [7:0] k;
        case ($urandom_range(0, 5))
            0, 1:    k = 8'h00;
            2:       k = 8'h2C;
            3:       k = 8'h15;
            4:       k = 8'h1E + 8'($urandom_range(0, 9));
            default: k = 8'($urandom);
        endcase
        return k;
    endfunction

    // Monitor: compare the queued expectation for the edge that just occurred.
    always begin
        exp_t e;
        @(posedge CLK);
        #2;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("background_number", background_number, e.bg);
            chk("HEXstate", HEXstate, e.hex);
            chk("level_idx", level_idx, e.lvl);
            chk("level_changed", level_changed, e.chg);
            chk("onehot", $countones(background_number), 1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        keycode0 = 8'h00; keycode1 = 8'h00; ts_collide = 1'b0; bs_collide = 1'b0;
        model_reset();
        @(negedge CLK);
        push_expected();
        @(negedge CLK);
        reset = 1'b0;
        model_edge();
        push_expected();

        idle(2);
        cycle(8'h00, 8'h2C, 1'b0, 1'b0, 1'b0);
        idle(6);
        for (int i = 0; i < 20; i++) cycle(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(5);
        ts_step();
        cycle(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(1);
        cycle(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(6);
        repeat (3) bs_step();
        bs_step();
        repeat (4) ts_step();
        cycle(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        idle(5);
        ts_step();
        cycle(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(3);
        cycle(8'h2C, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(5);
        repeat (7) ts_step();
        ts_step();
        cycle(8'h15, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(3);
        cycle(8'h2C, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(5);
        ts_step();
        cycle(8'h23, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(5);

        for (int i = 0; i < 800; i++)
            cycle(pick_key(), pick_key(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 149) == 0));

        idle(2);
        @(posedge CLK);
        #3;
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
